// File: rtl/pipe_stall_regs_pkg.sv
// pipe_pkg: shared constants and record types for the PC / IF/ID / ID/EX pipeline registers
package pipe_pkg;

    localparam int CTRL_W = 9;

    // Control-word bit positions: {RegDst, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, ALUOp[1:0]}
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [31:0]       NOP_INSTR   = 32'h0;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_STALLING,
        WD_TIMEOUT
    } wd_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       pc4;
        logic [31:0]       rd1;
        logic [31:0]       rd2;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              valid;
    } id_ex_t;

    // Saturating 4-bit increment for the stall-run counter
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pipe_stall_regs_if.sv
// pipe_stall_regs_if: hazard/redirect requests, decode inputs and pipeline-register outputs
// Counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_stall_regs_if;
    import pipe_pkg::*;

    logic              stall_req;
    logic              flush_req;
    logic [31:0]       branch_target;
    logic [31:0]       IF_instr;
    logic [CTRL_W-1:0] ID_ctrl_in;
    logic [31:0]       ID_rd1;
    logic [31:0]       ID_rd2;
    logic [31:0]       ID_imm;

    logic [31:0]       IF_pc;
    logic [31:0]       ID_instr;
    logic [31:0]       ID_pc4;
    logic              ID_valid;
    logic [CTRL_W-1:0] EX_ctrl;
    logic [31:0]       EX_pc4;
    logic [31:0]       EX_rd1;
    logic [31:0]       EX_rd2;
    logic [31:0]       EX_imm;
    logic [4:0]        EX_rs;
    logic [4:0]        EX_rt;
    logic [4:0]        EX_rd;
    logic              EX_valid;
    logic              stall_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport master (
        output stall_req, flush_req, branch_target, IF_instr, ID_ctrl_in, ID_rd1, ID_rd2, ID_imm,
        input  IF_pc, ID_instr, ID_pc4, ID_valid, EX_ctrl, EX_pc4, EX_rd1, EX_rd2, EX_imm,
               EX_rs, EX_rt, EX_rd, EX_valid, stall_timeout
`ifdef PIPE_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  stall_req, flush_req, branch_target, IF_instr, ID_ctrl_in, ID_rd1, ID_rd2, ID_imm,
        output IF_pc, ID_instr, ID_pc4, ID_valid, EX_ctrl, EX_pc4, EX_rd1, EX_rd2, EX_imm,
               EX_rs, EX_rt, EX_rd, EX_valid, stall_timeout
`ifdef PIPE_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_stall_regs_reg.sv
// pipe_reg: width-parameterised pipeline register with async reset, hold and clear (clear wins)
module pipe_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Clear loads an all-zero bubble; otherwise load unless held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q_q <= RST_VAL;
        else if (clear_i) q_q <= '0;
        else if (!hold_i) q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_stall_regs.sv
// pipe_stall_regs: PC, IF/ID and ID/EX registers with load-use stall, branch flush and stall watchdog
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush event counters.
module pipe_stall_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipe_stall_regs_if.slave  bus
);

    localparam logic [3:0] MAX_RUN = 4'(MAX_STALL);

    // Flush overrides stall, so a stall only takes effect when no flush is present
    logic stall_edge;
    assign stall_edge = bus.stall_req & ~bus.flush_req;

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_d, if_id_q;
    id_ex_t      id_ex_d, id_ex_q;

    // Next-PC selection and the advance-path contents of both pipeline registers
    always_comb begin
        pc_d    = bus.flush_req ? bus.branch_target : (bus.stall_req ? pc_q : pc_q + 32'd4);
        if_id_d = '{instr: bus.IF_instr, pc4: pc_q + 32'd4, valid: 1'b1};
        id_ex_d = '{ctrl:  bus.ID_ctrl_in,
                    pc4:   if_id_q.pc4,
                    rd1:   bus.ID_rd1,
                    rd2:   bus.ID_rd2,
                    imm:   bus.ID_imm,
                    rs:    if_id_q.instr[25:21],
                    rt:    if_id_q.instr[20:16],
                    rd:    if_id_q.instr[15:11],
                    valid: if_id_q.valid};
    end

    // Program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    // IF/ID holds on stall and is squashed to a nop on flush
    pipe_reg #(.W($bits(if_id_t))) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (bus.stall_req),
        .clear_i (bus.flush_req),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    // ID/EX takes a bubble on either stall or flush; a zero bubble clears MemRead and rt
    pipe_reg #(.W($bits(id_ex_t))) u_id_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (1'b0),
        .clear_i (bus.stall_req | bus.flush_req),
        .d_i     (id_ex_d),
        .q_o     (id_ex_q)
    );

    wd_state_e  wd_q;
    logic [3:0] run_q;
    logic       timeout_hit;
    assign timeout_hit = stall_edge && (run_q >= MAX_RUN);

    // Stall watchdog: run length tracks consecutive stall edges, TIMEOUT is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= WD_IDLE;
            run_q <= '0;
        end else begin
            run_q <= stall_edge ? sat_inc4(run_q) : 4'd0;
            wd_q  <= (wd_q == WD_TIMEOUT || timeout_hit) ? WD_TIMEOUT :
                     (stall_edge ? WD_STALLING : WD_IDLE);
        end
    end

    assign bus.IF_pc         = pc_q;
    assign bus.ID_instr      = if_id_q.instr;
    assign bus.ID_pc4        = if_id_q.pc4;
    assign bus.ID_valid      = if_id_q.valid;
    assign bus.EX_ctrl       = id_ex_q.ctrl;
    assign bus.EX_pc4        = id_ex_q.pc4;
    assign bus.EX_rd1        = id_ex_q.rd1;
    assign bus.EX_rd2        = id_ex_q.rd2;
    assign bus.EX_imm        = id_ex_q.imm;
    assign bus.EX_rs         = id_ex_q.rs;
    assign bus.EX_rt         = id_ex_q.rt;
    assign bus.EX_rd         = id_ex_q.rd;
    assign bus.EX_valid      = id_ex_q.valid;
    assign bus.stall_timeout = (wd_q == WD_TIMEOUT);

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters: effective stalls and all flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= (stall_edge && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
            flush_cnt_q <= (bus.flush_req && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule
